decode_stage: RTL

- Pipelined instruction decode stage for the RV64IM core.
- Accepts a 32-bit fetched instruction and its PC over a valid/ready handshake.
- Translates the instruction into the 8-bit operation code space consumed by the execute unit: 0-42 ALU ops, 43-46 stores, 47-52 branches, 53-58 jump/upper/system, 59-65 loads.
- Extracts register indices, the sign-extended 64-bit immediate and shamt into a registered output slot with backpressure, flush, and an illegal-instruction counter.

---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
//   in_*  : fetch -> decode (valid/ready, instruction, PC)
//   out_* : decode -> execute (valid/ready, decoded fields)
// slave  : view taken by the decode stage
// master : view taken by the surrounding fetch/execute logic
interface decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_op;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [63:0] out_imm;
   logic [5:0]  out_shamt;
   logic [63:0] out_pc;
   logic        out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_imm, out_shamt,
             out_pc, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_imm, out_shamt,
             out_pc, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV64IM decode stage: one registered output slot with valid/ready backpressure.
// Ports:
//   clk, reset_n   : core clock, asynchronous active-low reset
//   flush          : synchronous kill of the held bundle and the incoming instruction
//   bus            : decode_stage_if.slave (fetch input handshake, execute output bundle)
//   illegal_count  : saturating count of accepted illegal instructions
module decode_stage #(
   parameter logic [7:0]  ILLEGAL_OP = 8'hFF,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   decode_stage_if.slave    bus,
   output logic [CNT_W-1:0] illegal_count
);

   typedef struct packed {
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] imm;
      logic [5:0]  shamt;
      logic [63:0] pc;
      logic        illegal;
   } bundle_t;

   bundle_t          bundle_d, bundle_q;
   logic             out_valid_d, out_valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   logic [31:0] ins;
   logic [6:0]  opcode, funct7;
   logic [2:0]  f3;
   logic [7:0]  op_dec;
   logic [63:0] imm_dec;
   logic [5:0]  shamt_dec;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        accept;

   assign ins    = bus.in_instr;
   assign opcode = ins[6:0];
   assign f3     = ins[14:12];
   assign funct7 = ins[31:25];

   assign imm_i = {{52{ins[31]}}, ins[31:20]};
   assign imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};
   assign imm_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

   // Instruction decode; anything not matched keeps ILLEGAL_OP.
   always_comb begin
      op_dec    = ILLEGAL_OP;
      imm_dec   = '0;
      shamt_dec = '0;
      case (opcode)
         7'b0110011: begin
            case (funct7)
               7'b0000000: begin
                  case (f3)
                     3'd0: op_dec = 8'd0;
                     3'd1: op_dec = 8'd5;
                     3'd2: op_dec = 8'd8;
                     3'd3: op_dec = 8'd9;
                     3'd4: op_dec = 8'd2;
                     3'd5: op_dec = 8'd6;
                     3'd6: op_dec = 8'd3;
                     default: op_dec = 8'd4;
                  endcase
               end
               7'b0100000: begin
                  if (f3 == 3'd0) op_dec = 8'd1;
                  else if (f3 == 3'd5) op_dec = 8'd7;
               end
               7'b0000001: op_dec = 8'd10 + {5'b0, f3};
               default: ;
            endcase
         end
         7'b0010011: begin
            imm_dec = imm_i;
            case (f3)
               3'd0: op_dec = 8'd18;
               3'd2: op_dec = 8'd25;
               3'd3: op_dec = 8'd26;
               3'd4: op_dec = 8'd19;
               3'd6: op_dec = 8'd20;
               3'd7: op_dec = 8'd21;
               3'd1: begin
                  shamt_dec = ins[25:20];
                  if (ins[31:26] == 6'b000000) op_dec = 8'd22;
               end
               default: begin
                  shamt_dec = ins[25:20];
                  if (ins[31:26] == 6'b000000) op_dec = 8'd23;
                  else if (ins[31:26] == 6'b010000) op_dec = 8'd24;
               end
            endcase
         end
         7'b0011011: begin
            imm_dec = imm_i;
            // funct7 checks include ins[25]=0, so 32-bit shifts never see shamt[5].
            case (f3)
               3'd0: op_dec = 8'd29;
               3'd1: begin
                  shamt_dec = {1'b0, ins[24:20]};
                  if (funct7 == 7'b0000000) op_dec = 8'd30;
               end
               3'd5: begin
                  shamt_dec = {1'b0, ins[24:20]};
                  if (funct7 == 7'b0000000) op_dec = 8'd31;
                  else if (funct7 == 7'b0100000) op_dec = 8'd32;
               end
               default: ;
            endcase
         end
         7'b0111011: begin
            case (funct7)
               7'b0000000: begin
                  if (f3 == 3'd0) op_dec = 8'd33;
                  else if (f3 == 3'd1) op_dec = 8'd35;
                  else if (f3 == 3'd5) op_dec = 8'd36;
               end
               7'b0100000: begin
                  if (f3 == 3'd0) op_dec = 8'd34;
                  else if (f3 == 3'd5) op_dec = 8'd37;
               end
               7'b0000001: begin
                  if (f3 == 3'd0) op_dec = 8'd38;
                  else if (f3[2]) op_dec = 8'd35 + {5'b0, f3};
               end
               default: ;
            endcase
         end
         7'b0100011: begin
            imm_dec = imm_s;
            if (!f3[2]) op_dec = 8'd43 + {5'b0, f3};
         end
         7'b1100011: begin
            imm_dec = imm_b;
            if (f3 == 3'd0) op_dec = 8'd47;
            else if (f3 == 3'd1) op_dec = 8'd48;
            else if (f3[2]) op_dec = 8'd45 + {5'b0, f3};
         end
         7'b1101111: begin
            imm_dec = imm_j;
            op_dec  = 8'd53;
         end
         7'b1100111: begin
            imm_dec = imm_i;
            if (f3 == 3'd0) op_dec = 8'd54;
         end
         7'b0110111: begin
            imm_dec = imm_u;
            op_dec  = 8'd55;
         end
         7'b0010111: begin
            imm_dec = imm_u;
            op_dec  = 8'd56;
         end
         7'b1110011: begin
            imm_dec = imm_i;
            if (ins == 32'h0000_0073) op_dec = 8'd57;
            else if (ins == 32'h0010_0073) op_dec = 8'd58;
         end
         7'b0000011: begin
            imm_dec = imm_i;
            case (f3)
               3'd0: op_dec = 8'd59;
               3'd1: op_dec = 8'd60;
               3'd2: op_dec = 8'd61;
               3'd3: op_dec = 8'd65;
               3'd4: op_dec = 8'd62;
               3'd5: op_dec = 8'd63;
               3'd6: op_dec = 8'd64;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign bus.in_ready = !flush && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      cnt_d       = cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d      = 1'b1;
         bundle_d.op      = op_dec;
         bundle_d.rs1     = ins[19:15];
         bundle_d.rs2     = ins[24:20];
         bundle_d.rd      = ins[11:7];
         bundle_d.imm     = imm_dec;
         bundle_d.shamt   = shamt_dec;
         bundle_d.pc      = bus.in_pc;
         bundle_d.illegal = (op_dec == ILLEGAL_OP);
         if ((op_dec == ILLEGAL_OP) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_op      = bundle_q.op;
   assign bus.out_rs1     = bundle_q.rs1;
   assign bus.out_rs2     = bundle_q.rs2;
   assign bus.out_rd      = bundle_q.rd;
   assign bus.out_imm     = bundle_q.imm;
   assign bus.out_shamt   = bundle_q.shamt;
   assign bus.out_pc      = bundle_q.pc;
   assign bus.out_illegal = bundle_q.illegal;
   assign illegal_count   = cnt_q;

endmodule
